if_fetch_unit: RTL

//  IF-stage fetch engine that sits between the branch predictor and the instruction memory.

---
 rtl/if_pkg.sv | 25 ++
 rtl/if_fetch_fifo.sv | 46 ++++
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage fetch unit.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned INST_BYTES       = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_entry_t;

    // Address of the next sequential instruction.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + INST_BYTES;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Small FIFO of fetched instructions waiting for the ID stage.
// flush empties it in one cycle; push and pop may coincide.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    // Pointers and occupancy; pointers wrap naturally since depth is a power of 2.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage, no reset needed.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the fetch PC, issues one IMEM request at a time,
// queues returned instructions with their prediction, and handles EX redirects.
// Optional build macro IF_FETCH_PERF_EN adds perf_fetched/perf_dropped/perf_stall.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_stall,
`endif
    output logic [31:0] bpu_pc,
    input  logic        bpu_pred_taken,
    input  logic [31:0] bpu_pred_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     state;
    logic [31:0]      pc;
    logic [31:0]      req_addr;
    logic [31:0]      inflight_pc;
    logic             inflight_taken;
    logic [31:0]      inflight_target;
    logic             drop;

    logic             handshake;
    logic             resp_in_wait;
    logic             push;
    logic             pop;
    logic             discard;
    logic             can_issue;
    logic [31:0]      redirect_aligned;
    logic [31:0]      pred_next;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign handshake        = (state == REQ) && imem_req_ready;
    assign resp_in_wait     = (state == WAIT) && imem_resp_valid;
    assign push             = resp_in_wait && !drop && !redirect_valid;
    assign discard          = resp_in_wait && (drop || redirect_valid);
    assign pop              = id_valid && id_ready && !redirect_valid;
    // The outstanding request's slot is counted by only issuing from IDLE.
    assign can_issue        = (32'(fifo_count) + 1 <= FIFO_DEPTH);
    assign redirect_aligned = redirect_pc & ~32'h3;
    assign pred_next        = bpu_pred_taken ? bpu_pred_target : next_seq_pc(pc);

    assign bpu_pc         = pc;
    assign imem_req_valid = (state == REQ);
    // A redirect during REQ moves pc, but the pending request keeps its address.
    assign imem_req_addr  = (state == REQ) ? req_addr : pc;

    assign push_entry = '{pc: inflight_pc, inst: imem_resp_data,
                          pred_taken: inflight_taken, pred_target: inflight_target};

    // Fetch FSM, PC, in-flight capture and stale-response tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            req_addr        <= RESET_PC;
            inflight_pc     <= '0;
            inflight_taken  <= 1'b0;
            inflight_target <= '0;
            drop            <= 1'b0;
        end else begin
            // With drop set the pc already holds the redirect target; don't advance it.
            if (redirect_valid)          pc <= redirect_aligned;
            else if (handshake && !drop) pc <= pred_next;

            if (handshake) begin
                inflight_pc     <= req_addr;
                inflight_taken  <= bpu_pred_taken;
                inflight_target <= pred_next;
            end

            unique case (state)
                IDLE: begin
                    if (!redirect_valid && can_issue) begin
                        state    <= REQ;
                        req_addr <= pc;
                    end
                end
                REQ: begin
                    if (redirect_valid) drop  <= 1'b1;
                    if (imem_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        drop  <= 1'b0;
                        state <= IDLE;
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if_fetch_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head),
        .valid    (id_valid),
        .count    (fifo_count)
    );

    assign id_pc          = head.pc;
    assign id_inst        = head.inst;
    assign id_pred_taken  = head.pred_taken;
    assign id_pred_target = head.pred_target;

`ifdef IF_FETCH_PERF_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
            perf_stall   <= '0;
        end else begin
            if (push)                                   perf_fetched <= perf_fetched + 1;
            if (discard)                                perf_dropped <= perf_dropped + 1;
            if ((state == REQ) && !imem_req_ready)      perf_stall   <= perf_stall + 1;
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule
